// File: rtl/mem_test_engine_if.sv
// rtl/mem_test_engine_if.sv - command/data bus between the memory test engine and the PSRAM controller
interface mem_test_engine_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
);
    logic              mem_read;
    logic              mem_write;
    logic              mem_byte_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_busy;

    modport master (
        output mem_read, mem_write, mem_byte_write, mem_addr, mem_din,
        input  mem_dout, mem_busy
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_write, mem_addr, mem_din,
        output mem_dout, mem_busy
    );
endinterface

// File: rtl/mem_test_engine.sv
// rtl/mem_test_engine.sv - full-array write-then-read PSRAM tester with latency classing and error capture
module mem_test_engine #(
    parameter int ADDR_W        = 22,
    parameter int DATA_W        = 16,
    parameter int WORDS         = 2**22,
    parameter int LATENCY       = 4,
    parameter int TIMEOUT       = 64,
    parameter int STOP_ON_ERROR = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    mem_test_engine_if.master     mem,
    output logic [2:0]            state,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_code,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [DATA_W-1:0]     err_exp,
    output logic [DATA_W-1:0]     err_act,
    output logic [23:0]           wr_1x,
    output logic [23:0]           wr_2x,
    output logic [23:0]           rd_1x,
    output logic [23:0]           rd_2x
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    localparam int CYC_W  = $clog2(TIMEOUT + LATENCY + 12);
    localparam int INIT_N = 256 * TIMEOUT;
    localparam int INIT_W = $clog2(INIT_N);
    localparam logic [CYC_W-1:0]  C_TIMEOUT   = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0]  C_WR_1X     = CYC_W'(5 + LATENCY);
    localparam logic [CYC_W-1:0]  C_RD_1X     = CYC_W'(10 + LATENCY);
    localparam logic [CYC_W-1:0]  C_MIN_DONE  = CYC_W'(2);
    localparam logic [INIT_W-1:0] C_INIT_LAST = INIT_W'(INIT_N - 1);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic                r_rd;
    logic                r_wr;
    logic [CYC_W-1:0]    r_cyc;
    logic [INIT_W-1:0]   r_init_cnt;
    logic                r_done;
    logic                r_pass;
    logic [1:0]          r_fail_code;
    logic [15:0]         r_err_count;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [DATA_W-1:0]   r_err_exp;
    logic [DATA_W-1:0]   r_err_act;
    logic [23:0]         r_wr_1x, r_wr_2x, r_rd_1x, r_rd_2x;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [23:0] a24;
        logic [7:0]  h;
        logic [31:0] sh;
        a24 = 24'(a);
        h   = a24[7:0] ^ a24[15:8] ^ a24[23:16] ^ 8'hC3;
        sh  = 32'(a) % 32'(DATA_W);
        case (m)
            2'd0:    pattern = {(DATA_W/8){h}};
            2'd1:    pattern = DATA_W'(a);
            2'd2:    pattern = ~{(DATA_W/8){h}};
            default: pattern = DATA_W'(1) << sh;
        endcase
    endfunction

    function automatic logic [23:0] sat24(input logic [23:0] v);
        return (&v) ? v : v + 24'd1;
    endfunction

    logic              w_complete;
    logic              w_slow;
    logic              w_last;
    logic              w_mismatch;
    logic [ADDR_W-1:0] w_next_addr;
    logic [DATA_W-1:0] w_expected;

    // busy is ignored for the first two cycles so the controller has time to raise it
    assign w_complete  = (r_cyc >= C_MIN_DONE) && !mem.mem_busy;
    assign w_slow      = r_cyc > ((r_state == S_READ) ? C_RD_1X : C_WR_1X);
    assign w_last      = (r_addr == C_LAST_ADDR);
    assign w_next_addr = r_addr + ADDR_W'(1);
    assign w_expected  = pattern(r_mode, r_addr);
    assign w_mismatch  = (mem.mem_dout != w_expected);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_addr      <= '0;
            r_din       <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_cyc       <= '0;
            r_init_cnt  <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= 2'd0;
            r_err_count <= 16'd0;
            r_err_addr  <= '0;
            r_err_exp   <= '0;
            r_err_act   <= '0;
            r_wr_1x     <= 24'd0;
            r_wr_2x     <= 24'd0;
            r_rd_1x     <= 24'd0;
            r_rd_2x     <= 24'd0;
        end else begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        r_state     <= S_INIT;
                        r_mode      <= mode;
                        r_init_cnt  <= '0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_code <= 2'd0;
                        r_err_count <= 16'd0;
                        r_err_addr  <= '0;
                        r_err_exp   <= '0;
                        r_err_act   <= '0;
                        r_wr_1x     <= 24'd0;
                        r_wr_2x     <= 24'd0;
                        r_rd_1x     <= 24'd0;
                        r_rd_2x     <= 24'd0;
                    end
                end
                S_INIT: begin
                    if (!mem.mem_busy) begin
                        r_state <= S_WRITE;
                        r_addr  <= '0;
                        r_din   <= pattern(r_mode, '0);
                        r_wr    <= 1'b1;
                        r_cyc   <= '0;
                    end else if (r_init_cnt == C_INIT_LAST) begin
                        r_state     <= S_FAIL;
                        r_fail_code <= 2'd1;
                        r_done      <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + INIT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (w_complete) begin
                        if (w_slow) r_wr_2x <= sat24(r_wr_2x);
                        else        r_wr_1x <= sat24(r_wr_1x);
                        r_cyc <= '0;
                        if (w_last) begin
                            r_state <= S_READ;
                            r_addr  <= '0;
                            r_rd    <= 1'b1;
                        end else begin
                            r_addr <= w_next_addr;
                            r_din  <= pattern(r_mode, w_next_addr);
                            r_wr   <= 1'b1;
                        end
                    end else if (r_cyc == C_TIMEOUT) begin
                        r_state     <= S_FAIL;
                        r_fail_code <= 2'd2;
                        r_done      <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                S_READ: begin
                    if (w_complete) begin
                        if (w_slow) r_rd_2x <= sat24(r_rd_2x);
                        else        r_rd_1x <= sat24(r_rd_1x);
                        r_cyc <= '0;
                        // only the first mismatch of a run is captured
                        if (w_mismatch) begin
                            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                            if (r_err_count == 16'd0) begin
                                r_err_addr <= r_addr;
                                r_err_exp  <= w_expected;
                                r_err_act  <= mem.mem_dout;
                            end
                        end
                        if (w_mismatch && (STOP_ON_ERROR != 0)) begin
                            r_state <= S_FAIL;
                            r_done  <= 1'b1;
                        end else if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= !w_mismatch && (r_err_count == 16'd0);
                        end else begin
                            r_addr <= w_next_addr;
                            r_rd   <= 1'b1;
                        end
                    end else if (r_cyc == C_TIMEOUT) begin
                        r_state     <= S_FAIL;
                        r_fail_code <= 2'd3;
                        r_done      <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_read       = r_rd;
    assign mem.mem_write      = r_wr;
    assign mem.mem_byte_write = 1'b0;
    assign mem.mem_addr       = r_addr;
    assign mem.mem_din        = r_din;

    assign state     = r_state;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_code = r_fail_code;
    assign err_count = r_err_count;
    assign err_addr  = r_err_addr;
    assign err_exp   = r_err_exp;
    assign err_act   = r_err_act;
    assign wr_1x     = r_wr_1x;
    assign wr_2x     = r_wr_2x;
    assign rd_1x     = r_rd_1x;
    assign rd_2x     = r_rd_2x;
endmodule

// File: tb/tb_mem_test_engine.sv
// tb/tb_mem_test_engine.sv - randomized bench for mem_test_engine, one instance per STOP_ON_ERROR setting
module tb_mem_test_engine;
    localparam int AW = 22, DW = 16, NW = 16, LAT = 4, TO = 24;
    localparam int WR_THR = 5 + LAT, RD_THR = 10 + LAT;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0] mode = 2'd0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_checks = 0, n_pass = 0;
    int wlat[NW], rlat[NW];
    logic [DW-1:0] cmask[NW];
    int init_wait = 3, stuck_wr_addr = -1, cur_mode = 0;
    bit stuck_init = 1'b0;

    logic [2:0]    st[2];
    logic          dn[2], ps[2], mrd[2], mwr[2], mbw[2];
    logic [1:0]    fc[2];
    logic [15:0]   ec[2];
    logic [AW-1:0] ea[2], maddr[2];
    logic [DW-1:0] ee[2], eact[2], mdin[2];
    logic [23:0]   w1[2], w2[2], r1[2], r2[2];
    int n_wr[2], n_rd[2], max_rd[2], viol[2], last_wr_cyc[2];

    function automatic logic [DW-1:0] pat(int m, int a);
        int h;
        h = (a & 255) ^ ((a >> 8) & 255) ^ ((a >> 16) & 255) ^ 'hC3;
        case (m)
            0:       return DW'(h * 257);
            1:       return DW'(a);
            2:       return ~DW'(h * 257);
            default: return DW'(1) << (a % DW);
        endcase
    endfunction

    function automatic bit is2x(int n, int thr);
        int c;
        c = (n + 1 > 2) ? n + 1 : 2;
        return c > thr;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_test_engine_if #(.ADDR_W(AW), .DATA_W(DW)) u_if();

        mem_test_engine #(
            .ADDR_W(AW), .DATA_W(DW), .WORDS(NW), .LATENCY(LAT),
            .TIMEOUT(TO), .STOP_ON_ERROR(g)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start), .mode(mode), .mem(u_if),
            .state(st[g]), .done(dn[g]), .pass(ps[g]), .fail_code(fc[g]),
            .err_count(ec[g]), .err_addr(ea[g]), .err_exp(ee[g]), .err_act(eact[g]),
            .wr_1x(w1[g]), .wr_2x(w2[g]), .rd_1x(r1[g]), .rd_2x(r2[g])
        );

        // controller model: busy for a per-address number of cycles after each command
        int left = 0;
        bit stuck = 1'b0;
        logic [DW-1:0] mem_arr[NW];
        logic [DW-1:0] dout_r = '0;
        assign u_if.mem_busy = (left > 0) || stuck || stuck_init;
        assign u_if.mem_dout = dout_r;

        always @(posedge clk) begin
            if (reset) begin
                left  <= init_wait;
                stuck <= 1'b0;
            end else if (u_if.mem_write) begin
                mem_arr[u_if.mem_addr[3:0]] <= u_if.mem_din;
                left <= wlat[u_if.mem_addr[3:0]];
                if (int'(u_if.mem_addr) == stuck_wr_addr) stuck <= 1'b1;
            end else if (u_if.mem_read) begin
                dout_r <= mem_arr[u_if.mem_addr[3:0]] ^ cmask[u_if.mem_addr[3:0]];
                left   <= rlat[u_if.mem_addr[3:0]];
            end else if (left > 0) begin
                left <= left - 1;
            end
        end

        int nw = 0, nr = 0, mr = -1, vl = 0, lwc = 0;
        always @(negedge clk) begin
            if (reset) begin
                nw = 0; nr = 0; mr = -1; vl = 0;
            end else begin
                if ((u_if.mem_write && u_if.mem_read) || (u_if.mem_write && st[g] != 3'd2) ||
                    (u_if.mem_read && st[g] != 3'd3) || u_if.mem_byte_write) vl++;
                if (u_if.mem_write) begin
                    if (int'(u_if.mem_addr) != nw || u_if.mem_din != pat(cur_mode, nw)) vl++;
                    nw++;
                    lwc = cyc_n;
                end
                if (u_if.mem_read) begin
                    if (int'(u_if.mem_addr) != nr) vl++;
                    mr = int'(u_if.mem_addr);
                    nr++;
                end
            end
        end

        assign mrd[g] = u_if.mem_read;
        assign mwr[g] = u_if.mem_write;
        assign mbw[g] = u_if.mem_byte_write;
        assign maddr[g] = u_if.mem_addr;
        assign mdin[g] = u_if.mem_din;
        assign n_wr[g] = nw;
        assign n_rd[g] = nr;
        assign max_rd[g] = mr;
        assign viol[g] = vl;
        assign last_wr_cyc[g] = lwc;
    end

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        init_wait = $urandom_range(0, 6);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start(int m, bit track);
        @(posedge clk); #1 start = 1'b1; mode = 2'(m);
        if (track) cur_mode = m;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int k = 0;
        while (!(dn[0] && dn[1]) && k < 20000) begin @(negedge clk); k++; end
        check_eq({tag, ".done_reached"}, 64'(dn[0] && dn[1]), 1);
    endtask

    task automatic set_lat(int kind);
        for (int a = 0; a < NW; a++) begin
            bit slow;
            slow = (kind == 1) ? (a % 2 == 1) : (kind == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
            wlat[a] = slow ? $urandom_range(WR_THR, TO - 2) : $urandom_range(0, WR_THR - 1);
            rlat[a] = slow ? $urandom_range(RD_THR, TO - 2) : $urandom_range(0, RD_THR - 1);
            cmask[a] = '0;
        end
        if (kind == 2) begin
            wlat[1] = WR_THR - 1; wlat[2] = WR_THR;
            rlat[1] = RD_THR - 1; rlat[2] = RD_THR;
        end
    endtask

    task automatic check_zero(string tag);
        for (int g = 0; g < 2; g++) begin
            string t;
            t = $sformatf("%s.i%0d", tag, g);
            check_eq({t, ".state"}, st[g], 0);
            check_eq({t, ".done_pass"}, {dn[g], ps[g]}, 0);
            check_eq({t, ".fail_code"}, fc[g], 0);
            check_eq({t, ".err"}, {ec[g], ea[g], ee[g]}, 0);
            check_eq({t, ".err_act"}, eact[g], 0);
            check_eq({t, ".wr_cnt"}, {w1[g], w2[g]}, 0);
            check_eq({t, ".rd_cnt"}, {r1[g], r2[g]}, 0);
            check_eq({t, ".bus"}, {maddr[g], mdin[g], mrd[g], mwr[g], mbw[g]}, 0);
        end
    endtask

    task automatic check_run(string tag);
        for (int g = 0; g < 2; g++) begin
            int first = -1, nerr = 0, last_rd, e1w = 0, e2w = 0, e1r = 0, e2r = 0;
            bit stop;
            string t;
            t = $sformatf("%s.stop%0d", tag, g);
            for (int a = 0; a < NW; a++) if (cmask[a] != 0) begin nerr++; if (first < 0) first = a; end
            stop = (g == 1) && (first >= 0);
            last_rd = stop ? first : NW - 1;
            for (int a = 0; a < NW; a++) if (is2x(wlat[a], WR_THR)) e2w++; else e1w++;
            for (int a = 0; a <= last_rd; a++) if (is2x(rlat[a], RD_THR)) e2r++; else e1r++;
            check_eq({t, ".state"}, st[g], stop ? 5 : 4);
            check_eq({t, ".done"}, dn[g], 1);
            check_eq({t, ".pass"}, ps[g], nerr == 0);
            check_eq({t, ".fail_code"}, fc[g], 0);
            check_eq({t, ".err_count"}, ec[g], stop ? 1 : nerr);
            check_eq({t, ".wr_1x"}, w1[g], e1w);
            check_eq({t, ".wr_2x"}, w2[g], e2w);
            check_eq({t, ".rd_1x"}, r1[g], e1r);
            check_eq({t, ".rd_2x"}, r2[g], e2r);
            check_eq({t, ".writes"}, n_wr[g], NW);
            check_eq({t, ".reads"}, n_rd[g], last_rd + 1);
            check_eq({t, ".max_rd"}, max_rd[g], last_rd);
            check_eq({t, ".bus_rules"}, viol[g], 0);
            if (first >= 0) begin
                check_eq({t, ".err_addr"}, ea[g], first);
                check_eq({t, ".err_exp"}, ee[g], pat(cur_mode, first));
                check_eq({t, ".err_act"}, eact[g], pat(cur_mode, first) ^ cmask[first]);
            end
        end
    endtask

    initial begin
        int k, t0;
        set_lat(0);
        do_reset();
        @(negedge clk);
        check_zero("reset");
        repeat (8) @(negedge clk);
        check_eq("idle.no_cmds", n_wr[0] + n_rd[0] + n_wr[1] + n_rd[1] + viol[0] + viol[1], 0);

        // all accesses fast; a stray start mid-run must be ignored
        set_lat(0); do_reset(); pulse_start(0, 1);
        k = 0;
        while (n_wr[0] < 5 && k < 2000) begin @(negedge clk); k++; end
        pulse_start(3, 0);
        wait_done("hash_1x"); check_run("hash_1x");

        set_lat(1); do_reset(); pulse_start(1, 1);
        wait_done("odd_2x"); check_run("odd_2x");

        for (int i = 0; i < 4; i++) begin
            string t;
            t = $sformatf("rand%0d", i);
            set_lat(2);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                cmask[$urandom_range(0, NW - 1)] = DW'($urandom_range(1, 65535));
            do_reset(); pulse_start(i, 1);
            wait_done(t); check_run(t);
        end

        set_lat(2); cmask[5] = 16'h0001;
        do_reset(); pulse_start(0, 1);
        wait_done("corrupt5"); check_run("corrupt5");

        set_lat(0); cmask[3] = DW'($urandom_range(1, 65535)); cmask[9] = DW'($urandom_range(1, 65535));
        do_reset(); pulse_start(2, 1);
        wait_done("corrupt3_9"); check_run("corrupt3_9");

        // controller never finishes initialising
        set_lat(0); stuck_init = 1'b1; do_reset(); pulse_start(0, 1);
        t0 = cyc_n; k = 0;
        while (st[0] == 3'd1 && k < 20000) begin @(negedge clk); k++; end
        check_eq("init_to.cycles", cyc_n - t0, 256 * TO);
        wait_done("init_to");
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("init_to.i%0d.state", g), st[g], 5);
            check_eq($sformatf("init_to.i%0d.code", g), fc[g], 1);
            check_eq($sformatf("init_to.i%0d.pass", g), ps[g], 0);
            check_eq($sformatf("init_to.i%0d.cmds", g), n_wr[g] + n_rd[g] + viol[g], 0);
        end
        stuck_init = 1'b0;

        // busy sticks during the write at address 2
        set_lat(0); stuck_wr_addr = 2; do_reset(); pulse_start(1, 1);
        wait_done("wr_to");
        check_eq("wr_to.cycles", cyc_n - last_wr_cyc[0], TO + 1);
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("wr_to.i%0d.state", g), st[g], 5);
            check_eq($sformatf("wr_to.i%0d.code", g), fc[g], 2);
            check_eq($sformatf("wr_to.i%0d.addr", g), maddr[g], 2);
            check_eq($sformatf("wr_to.i%0d.wr_total", g), w1[g] + w2[g], 2);
            check_eq($sformatf("wr_to.i%0d.rd_total", g), r1[g] + r2[g], 0);
            check_eq($sformatf("wr_to.i%0d.bus_rules", g), viol[g], 0);
        end
        stuck_wr_addr = -1;

        // reset in the middle of the read at address 7, then a clean rerun
        set_lat(0); do_reset(); pulse_start(0, 1);
        k = 0;
        while (!(mrd[0] && maddr[0] == AW'(7)) && k < 5000) begin @(negedge clk); k++; end
        check_eq("mid_reset.saw_read7", {mrd[0], maddr[0]}, {1'b1, AW'(7)});
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_reset");
        @(posedge clk); #1 reset = 1'b0;
        pulse_start(2, 1);
        wait_done("rerun"); check_run("rerun");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_test_engine.md
MEM_TEST_ENGINE -- requirements
Module: mem_test_engine

Interface
REQ-001 Parameter ADDR_W, default 22: word address width toward the PSRAM controller.
REQ-002 Parameter DATA_W, default 16: data width; SHALL be a multiple of 8 and at most 64.
REQ-003 Parameter WORDS, default 2**22: number of words tested, addresses 0..WORDS-1.
REQ-004 Parameter LATENCY, default 4: controller latency, used for the 1x/2x split.
REQ-005 Parameter TIMEOUT, default 64: per-access cycle limit.
REQ-006 Parameter STOP_ON_ERROR, default 1: 1 = abort on first mismatch; 0 = count mismatches and continue.
REQ-007 clk  in  1  single clock for all logic.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that launches a run; accepted only in IDLE, DONE or FAIL.
REQ-010 mode  in  2  data pattern, sampled at start: 0 hash, 1 address, 2 inverted hash, 3 walking one.
REQ-011 mem_read, mem_write  out  1  one-cycle command pulses to the controller.
REQ-012 mem_byte_write  out  1  held 0 (full-word accesses only).
REQ-013 mem_addr  out  ADDR_W  access address.
REQ-014 mem_din  out  DATA_W  write data.
REQ-015 mem_dout  in  DATA_W  read data, valid when mem_busy falls after a read.
REQ-016 mem_busy  in  1  controller busy; high after reset until the controller initialises.
REQ-017 state  out  3  IDLE=0, INIT=1, WRITE=2, READ=3, DONE=4, FAIL=5.
REQ-018 done, pass  out  1  done is high in DONE or FAIL; pass is high only in DONE with err_count==0.
REQ-019 fail_code  out  2  0 none, 1 init timeout, 2 write timeout, 3 read timeout.
REQ-020 err_count  out  16  mismatch count, saturating at 16'hFFFF.
REQ-021 err_addr, err_exp, err_act  out  ADDR_W/DATA_W/DATA_W  first-mismatch capture.
REQ-022 wr_1x, wr_2x, rd_1x, rd_2x  out  24 each  latency-class counters, saturating.

Function
REQ-023 The pattern P(a) for hash is h = a[7:0]^a[15:8]^a[23:16]^8'hC3, with a zero-extended to 24 bits and h replicated across DATA_W.
- address mode: a zero-extended or truncated to DATA_W.
- inverted hash: ~hash.
- walking one: 1 << (a mod DATA_W).
REQ-024 On start: clear all counters and captures, set fail_code=0, latch mode, enter INIT.
REQ-025 INIT SHALL leave for WRITE at address 0 on the first cycle mem_busy==0, and SHALL enter FAIL with fail_code=1 when mem_busy is still 1 after 256*TIMEOUT cycles.
REQ-026 Access cycle counter cyc:
- cyc=0: the engine pulses mem_write (with mem_din=P(addr)) or mem_read, and mem_addr is stable for the whole access.
- cyc>=2: mem_busy==0 completes the access.
- cyc==TIMEOUT without completion: the engine enters FAIL with code 2 (write) or 3 (read).
REQ-027 On completion, if cyc > (write: 5+LATENCY, read: 10+LATENCY) the 2x counter increments, otherwise the 1x counter increments.
REQ-028 Read completion SHALL compare mem_dout against P(addr). On the first mismatch it SHALL capture err_addr, err_exp and err_act and increment err_count; later mismatches SHALL increment err_count only.
REQ-029 With STOP_ON_ERROR=1 a mismatch SHALL enter FAIL with fail_code=0 in the next cycle; with STOP_ON_ERROR=0 the scan SHALL continue.
REQ-030 Address step:
- After completion at WORDS-1, WRITE enters READ at address 0 and READ enters DONE; the address never wraps past WORDS-1.
- Otherwise the address increments by 1, and the next access begins one cycle after completion.
REQ-031 A start pulse outside IDLE/DONE/FAIL SHALL be ignored, with no effect on state or counters.
REQ-032 At most one of mem_read and mem_write SHALL be high in any cycle, and neither while the engine is in IDLE, INIT, DONE or FAIL.
REQ-033 Counter and err_count increments SHALL saturate and never wrap.

Reset
REQ-034 reset=1 SHALL force the following at the next clk edge, regardless of state, including mid-access:
- state=IDLE; all counters, captures, fail_code, done and pass = 0.
- mem_read=mem_write=0, mem_addr=0, mem_din=0, latched mode=0.
REQ-035 After reset the engine SHALL wait in IDLE for start and SHALL issue no commands.

Verification
REQ-036 Model with 1x latency, WORDS=16, mode 0, start -> exactly 16 writes then 16 reads; DONE, pass=1, wr_1x=rd_1x=16, wr_2x=rd_2x=0.
REQ-037 Model forcing 2x latency on odd addresses, WORDS=8 -> wr_1x=wr_2x=rd_1x=rd_2x=4, pass=1.
REQ-038 STOP_ON_ERROR=1, model corrupts address 5 bit 0 -> FAIL, err_addr=5, err_exp=P(5), err_act=P(5)^1, err_count=1, no read issued to address 6.
REQ-039 STOP_ON_ERROR=0, addresses 3 and 9 corrupted, WORDS=16 -> DONE, pass=0, err_count=2, err_addr=3.
REQ-040 mem_busy held high forever -> FAIL with fail_code=1 after 256*TIMEOUT cycles; busy stuck high during write at address 2 -> fail_code=2 at cyc==TIMEOUT.
REQ-041 reset asserted during the read at address 7, then start again -> IDLE next cycle with outputs zeroed, and the second run completes with pass=1.
